// File: rtl/counter_pkg.sv
// Shared types and parameter limits for the
// modulo-N up/down counter.
package counter_pkg;

  typedef enum logic {
    CNT_WRAP     = 1'b0,
    CNT_SATURATE = 1'b1
  } cnt_mode_e;

  localparam int WIDTH_MIN   = 2;
  localparam int WIDTH_MAX   = 16;
  localparam int MODULUS_MIN = 2;

  function automatic bit params_ok(
    input int width,
    input int modulus
  );
    bit w_ok;
    bit m_ok;
    w_ok = (width >= WIDTH_MIN) &&
           (width <= WIDTH_MAX);
    m_ok = w_ok &&
           (modulus >= MODULUS_MIN) &&
           (modulus <= (1 << width));
    return w_ok && m_ok;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// One JK bistable; the parent computes J/K
// from the desired next state.
module jk_cell (
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= 1'b0;
    end else begin
      unique case ({j, k})
        2'b00:   q <= q;
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        default: q <= ~q;
      endcase
    end
  end

endmodule

// File: rtl/updown_counter_n.sv
// Modulo-N up/down counter with load, built
// from JK cells; wrap or saturate at bounds.
module updown_counter_n
  import counter_pkg::*;
#(
  parameter int        WIDTH   = 4,
  parameter int        MODULUS = 2 ** WIDTH,
  parameter cnt_mode_e MODE    = CNT_WRAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             terminal,
  output logic             wrapped,
  output logic             saturated
);

  if (!params_ok(WIDTH, MODULUS)) begin : g_bad
    $error("updown_counter_n: illegal WIDTH/MODULUS");
  end

  localparam logic [WIDTH-1:0] MAX_CNT =
    WIDTH'(MODULUS - 1);
  localparam bit SAT = (MODE == CNT_SATURATE);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] ld_val;
  logic             at_max;
  logic             at_zero;
  logic             up_step;
  logic             dn_step;
  logic             boundary;

  assign count   = q;
  assign at_max  = (q == MAX_CNT);
  assign at_zero = (q == '0);
  assign up_step = enable & ~load & ~dir;
  assign dn_step = enable & ~load & dir;

  assign boundary = (up_step & at_max) |
                    (dn_step & at_zero);
  assign terminal = boundary;

  // Out-of-range loads clamp to the top value
  assign ld_val =
    (32'(load_value) >= 32'(MODULUS)) ?
    MAX_CNT : load_value;

  always_comb begin
    nxt = q;
    unique case (1'b1)
      load: nxt = ld_val;
      up_step: begin
        if (at_max) nxt = SAT ? MAX_CNT : '0;
        else        nxt = q + 1'b1;
      end
      dn_step: begin
        if (at_zero) nxt = SAT ? '0 : MAX_CNT;
        else         nxt = q - 1'b1;
      end
      default: nxt = q;
    endcase
  end

  assign j = nxt & ~q;
  assign k = ~nxt & q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .j     (j[i]),
      .k     (k[i]),
      .q     (q[i])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wrapped <= 1'b0;
    else        wrapped <= boundary;
  end

  if (SAT) begin : g_sat
    logic sat_q;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)      sat_q <= 1'b0;
      else if (load)   sat_q <= 1'b0;
      else if (enable) sat_q <= boundary;
    end
    assign saturated = sat_q;
  end else begin : g_nosat
    assign saturated = 1'b0;
  end

endmodule
